kj_sync_tx: RTL and testbench
=============================

// Module: kj_sync_tx
// PURPOSE
//  Transmit side of the K/J sync link: serialises one frame per start request.
//  Frame = sync preamble, then a payload of K/J symbols on (out_k, out_j, out_en).
//  Drives the in_k/in_j/in_en inputs of the sync detector, in the functional path and as BIST stimulus.
//  Optional error injection corrupts the preamble, which exercises the detector's sync-error path.
// PARAMETERS
//  SYNC_LEN   6          number of preamble symbols (>=2)
//  SYNC_PAT   6'b101011  preamble, sent MSB first; bit 1 = K, bit 0 = J
//  PAYLOAD_W  8          payload bits per frame (>=1)
//  GAP_CYC    2          idle cycles after payload before done (0 = no gap)
// PORTS
//  CLK         in   1          rising-edge clock
//  RST         in   1          asynchronous, active-high reset
//  start       in   1          frame request; sampled only in IDLE
//  payload     in   PAYLOAD_W  frame data; captured on accepted start
//  inject_err  in   1          captured on accepted start; corrupts last preamble symbol
//  out_k       out  1          K line (registered)
//  out_j       out  1          J line (registered)
//  out_en      out  1          symbol valid (registered)
//  busy        out  1          high from cycle after accepted start until done
//  done        out  1          one-cycle pulse at frame completion
// BEHAVIOUR
//  - Reset (async, RST=1): state=IDLE; out_k=out_j=out_en=busy=done=0; counters cleared.
//  - Symbol coding when out_en=1: K={k,j}=2'b10, J=2'b01. When out_en=0, k=j=0.
//    2'b11 and 2'b00 with en=1 are never driven.
//  - FSM states IDLE -> SYNC -> DATA -> GAP -> IDLE (GAP skipped when GAP_CYC=0).
//  - IDLE: outputs 0. start=1 at edge t is accepted; payload and inject_err are latched at t.
//  - Latency: the first preamble symbol (SYNC_PAT[SYNC_LEN-1]) is on the outputs after edge t+1.
//  - SYNC: SYNC_LEN cycles, one symbol per cycle, MSB first.
//    If inject_err was latched, the final preamble symbol is inverted (K<->J).
//  - DATA: PAYLOAD_W cycles, LSB first; bit 1 -> K, bit 0 -> J.
//  - GAP: GAP_CYC cycles with out_en=0.
//  - Completion: done=1 for one cycle, in the first cycle back in IDLE; busy drops in that same cycle.
//  - Frame length: busy is high for SYNC_LEN+PAYLOAD_W+GAP_CYC cycles.
//  - Back-to-back: start asserted in the done cycle is accepted.
//    The next preamble starts the following cycle (1 idle cycle between frames minimum).
//  - start while busy: ignored; the in-flight frame and its latched payload are unaffected.
//  - Changes on payload/inject_err after acceptance have no effect.
//  - RST mid-frame: outputs drop to 0 immediately (async). No done pulse.
//    After RST deasserts, the block sits in IDLE.
//  - Counters sized $clog2(max(SYNC_LEN,PAYLOAD_W,GAP_CYC)+1). No wrap: each phase ends on terminal count.
// STRUCTURE
//  - Shared header kj_defs.vh: symbol codes SYM_K=2'b10, SYM_J=2'b01, SYM_IDLE=2'b00;
//    FSM state encodings; default SYNC_PAT.
//    The sync detector includes the same header so both ends agree.
//  - One sub-module, kj_shift_out: loadable PAYLOAD_W shift register, LSB-first, with shift-enable.
//    The preamble is indexed directly from SYNC_PAT.
//  - Top holds the FSM, phase counter and output registers.
// TESTING
//  1 Reset: RST=1 for 2 cycles with start=1 -> all outputs 0, no frame starts.
//    Release RST, start low -> outputs stay 0.
//  2 Nominal frame: start pulse with payload=8'hA5, inject_err=0.
//    -> symbols K J K J K K, then payload LSB-first K J K J J K J K, then 2 idle cycles.
//    -> done pulse at cycle 17 after start; the sync detector asserts synced and not err.
//  3 Error injection: payload=8'h00, inject_err=1.
//    -> preamble K J K J K J, then 8 x J; detector raises sync_err; done still pulses at cycle 17.
//  4 Busy/back-to-back: start held high continuously.
//    -> frames repeat every 17 cycles; busy low only in the done cycle.
//    -> payload change mid-frame is not seen until the next frame.
//  5 Mid-frame reset: assert RST during DATA bit 3.
//    -> out_en=0 immediately, no done pulse; next start gives a full clean frame.
//  6 Parameter corner: GAP_CYC=0, PAYLOAD_W=1, payload=1.
//    -> 6 preamble symbols + K, then done; frame period 8 cycles under continuous start.

Source files
------------

// File: rtl/kj_sync_tx_pkg.sv
// ---------------------------------------------------------------------------
// kj_sync_tx_pkg
// Shared definitions for both ends of the K/J sync link: symbol codes
// ({k,j} pairs), FSM state encoding, the default preamble, and a helper that
// sizes the phase counter.
// ---------------------------------------------------------------------------
package kj_sync_tx_pkg;

    // Symbol codes as {k, j}. 2'b11 is never driven.
    localparam logic [1:0] SYM_K    = 2'b10;
    localparam logic [1:0] SYM_J    = 2'b01;
    localparam logic [1:0] SYM_IDLE = 2'b00;

    // Default preamble, sent MSB first (1 = K, 0 = J).
    localparam int              DEF_SYNC_LEN = 6;
    localparam logic [5:0]      DEF_SYNC_PAT = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Width of a counter that can hold the longest phase length.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/kj_sync_tx_if.sv
// ---------------------------------------------------------------------------
// kj_sync_tx_if
// Request / symbol bundle of the K/J transmitter.
//   start, payload, inject_err : frame request side (driven by master)
//   out_k, out_j, out_en       : serial symbol lines (driven by slave)
//   busy, done                 : frame status (driven by slave)
// ---------------------------------------------------------------------------
interface kj_sync_tx_if #(
    parameter int PAYLOAD_W = 8
);
    logic                 start;
    logic [PAYLOAD_W-1:0] payload;
    logic                 inject_err;
    logic                 out_k;
    logic                 out_j;
    logic                 out_en;
    logic                 busy;
    logic                 done;

    modport master (
        output start, payload, inject_err,
        input  out_k, out_j, out_en, busy, done
    );

    modport slave (
        input  start, payload, inject_err,
        output out_k, out_j, out_en, busy, done
    );
endinterface

// File: rtl/kj_sync_tx_shift_out.sv
// ---------------------------------------------------------------------------
// kj_sync_tx_shift_out
// Loadable LSB-first shift register holding the frame payload.
//   clk   : rising-edge clock
//   load  : capture din (has priority over shift)
//   shift : move toward the LSB by one bit
//   din   : parallel payload
//   lsb   : current bit to transmit
// Holds data only, so it carries no reset.
// ---------------------------------------------------------------------------
module kj_sync_tx_shift_out #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 load,
    input  logic                 shift,
    input  logic [PAYLOAD_W-1:0] din,
    output logic                 lsb
);
    logic [PAYLOAD_W-1:0] sh_p0;

    always_ff @(posedge clk) begin
        if (load) begin
            sh_p0 <= din;
        end else if (shift) begin
            sh_p0 <= sh_p0 >> 1;
        end
    end

    assign lsb = sh_p0[0];
endmodule

// File: rtl/kj_sync_tx.sv
// ---------------------------------------------------------------------------
// kj_sync_tx
// Transmit side of the K/J sync link. Each accepted start sends a preamble
// (SYNC_PAT, MSB first), then PAYLOAD_W payload bits LSB first, then GAP_CYC
// idle cycles, and pulses done.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : kj_sync_tx_if.slave (start/payload/inject_err in; symbols, busy,
//         done out; all outputs registered)
// The FSM runs one cycle ahead of the output registers: the state seen in a
// cycle decides the symbol shown in the next one. That is why the FSM returns
// to IDLE one cycle before done shows, which lets a start held high be taken
// on the same edge that raises done.
// ---------------------------------------------------------------------------
module kj_sync_tx
    import kj_sync_tx_pkg::*;
#(
    parameter int                    SYNC_LEN  = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0]   SYNC_PAT  = SYNC_LEN'(DEF_SYNC_PAT),
    parameter int                    PAYLOAD_W = 8,
    parameter int                    GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst,
    kj_sync_tx_if.slave bus
);
    localparam int CNT_W = cnt_width(SYNC_LEN, PAYLOAD_W, GAP_CYC);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t           state_p0, state_nxt;
    logic [CNT_W-1:0] cnt_p0, cnt_nxt;
    logic             err_p0;
    logic             load, shift, data_bit, pre_bit;
    logic [1:0]       sym_nxt;
    logic             en_nxt;
    logic             k_p1, j_p1, en_p1, busy_p1, done_p1;

    kj_sync_tx_shift_out #(.PAYLOAD_W(PAYLOAD_W)) u_shift (
        .clk   (clk),
        .load  (load),
        .shift (shift),
        .din   (bus.payload),
        .lsb   (data_bit)
    );

    // Preamble bit for the current count, MSB first.
    always_comb begin
        pre_bit = 1'b0;
        for (int i = 0; i < SYNC_LEN; i++) begin
            if (cnt_p0 == CNT_W'(SYNC_LEN - 1 - i)) pre_bit = SYNC_PAT[i];
        end
    end

    // Stage p0: FSM state and phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= ST_IDLE;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
        end
    end

    // Error flag is only read after a load, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) err_p0 <= bus.inject_err;
    end

    always_comb begin
        state_nxt = state_p0;
        cnt_nxt   = cnt_p0;
        load      = 1'b0;
        shift     = 1'b0;
        sym_nxt   = SYM_IDLE;
        en_nxt    = 1'b0;
        case (state_p0)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_SYNC;
                    cnt_nxt   = '0;
                    load      = 1'b1;
                end
            end
            ST_SYNC: begin
                en_nxt = 1'b1;
                // Injected error flips only the final preamble symbol.
                if ((pre_bit ^ (err_p0 && (cnt_p0 == SYNC_LAST))) == 1'b1) sym_nxt = SYM_K;
                else sym_nxt = SYM_J;
                if (cnt_p0 == SYNC_LAST) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_p0 + 1'b1;
                end
            end
            ST_DATA: begin
                en_nxt  = 1'b1;
                sym_nxt = data_bit ? SYM_K : SYM_J;
                shift   = 1'b1;
                if (cnt_p0 == DATA_LAST) begin
                    state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_p0 + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_p0 == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_p0 + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stage p1: registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_p1    <= 1'b0;
            j_p1    <= 1'b0;
            en_p1   <= 1'b0;
            busy_p1 <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            k_p1    <= sym_nxt[1];
            j_p1    <= sym_nxt[0];
            en_p1   <= en_nxt;
            busy_p1 <= (state_p0 != ST_IDLE);
            // First cycle back in IDLE after a frame; a reset clears busy, so
            // an aborted frame never produces done.
            done_p1 <= busy_p1 && (state_p0 == ST_IDLE);
        end
    end

    assign bus.out_k  = k_p1;
    assign bus.out_j  = j_p1;
    assign bus.out_en = en_p1;
    assign bus.busy   = busy_p1;
    assign bus.done   = done_p1;
endmodule

// File: tb/tb_kj_sync_tx.sv
module tb_kj_sync_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    kj_sync_tx_if #(.PAYLOAD_W(8)) bus ();
    kj_sync_tx_if #(.PAYLOAD_W(1)) bus2 ();

    kj_sync_tx #(.PAYLOAD_W(8), .GAP_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    kj_sync_tx #(.PAYLOAD_W(1), .GAP_CYC(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    // {en,k,j} codes
    localparam logic [2:0] K = 3'b110;
    localparam logic [2:0] J = 3'b101;
    localparam logic [2:0] I = 3'b000;

    localparam logic [47:0] SEQ_A5  = {K,J,K,J,K,K, K,J,K,J,J,K,J,K, I,I};
    localparam logic [47:0] SEQ_ERR = {K,J,K,J,K,J, J,J,J,J,J,J,J,J, I,I};
    localparam logic [47:0] SEQ_0F  = {K,J,K,J,K,K, K,K,K,K,J,J,J,J, I,I};
    localparam logic [20:0] SEQ_P1  = {K,J,K,J,K,K, K};

    function automatic logic [4:0] obs1();
        return {bus.busy, bus.done, bus.out_en, bus.out_k, bus.out_j};
    endfunction

    function automatic logic [4:0] obs2();
        return {bus2.busy, bus2.done, bus2.out_en, bus2.out_k, bus2.out_j};
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {busy,done,en,k,j}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge. Applies the new request inputs,
    // then checks the 16 frame cycles and the done cycle.
    task automatic frame(input string tag, input logic [47:0] seq, input logic hold,
                         input logic [7:0] np, input logic ne);
        bus.start      = hold;
        bus.payload    = np;
        bus.inject_err = ne;
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("%s_sym%0d", tag, i), obs1(), {2'b10, seq[(15-i)*3 +: 3]});
        end
        step();
        chk({tag, "_done"}, obs1(), 5'b01000);
    endtask

    initial begin
        bus.start       = 1'b1;
        bus.payload     = 8'hA5;
        bus.inject_err  = 1'b0;
        bus2.start      = 1'b0;
        bus2.payload    = 1'b1;
        bus2.inject_err = 1'b0;

        // 1: reset with start high, then idle
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("t1_rst%0d", i), obs1(), 5'b00000);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t1_idle%0d", i), obs1(), 5'b00000);
        end

        // 2: nominal frame, payload A5
        bus.payload = 8'hA5;
        bus.inject_err = 1'b0;
        bus.start = 1'b1;
        step();
        chk("t2_accept", obs1(), 5'b00000);
        frame("t2", SEQ_A5, 1'b0, 8'hFF, 1'b1);
        step();
        chk("t2_after", obs1(), 5'b00000);

        // 3: error injection, payload 00
        bus.payload = 8'h00;
        bus.inject_err = 1'b1;
        bus.start = 1'b1;
        step();
        chk("t3_accept", obs1(), 5'b00000);
        frame("t3", SEQ_ERR, 1'b0, 8'hFF, 1'b0);

        // 4: start held, payload changed mid-frame
        step();
        bus.payload = 8'hA5;
        bus.inject_err = 1'b0;
        bus.start = 1'b1;
        step();
        frame("t4a", SEQ_A5, 1'b1, 8'h0F, 1'b0);
        frame("t4b", SEQ_0F, 1'b0, 8'h00, 1'b0);
        step();
        chk("t4_after", obs1(), 5'b00000);

        // 5: reset during DATA bit 3
        bus.payload = 8'hA5;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t5_pre%0d", i), obs1(), {2'b10, SEQ_A5[(15-i)*3 +: 3]});
        end
        #2 rst = 1'b1;
        #1 chk("t5_rst_async", obs1(), 5'b00000);
        step();
        step();
        chk("t5_rst_hold", obs1(), 5'b00000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t5_nodone%0d", i), obs1(), 5'b00000);
        end
        bus.start = 1'b1;
        step();
        frame("t5_clean", SEQ_A5, 1'b0, 8'h00, 1'b0);

        // 6: GAP_CYC=0, PAYLOAD_W=1, continuous start for two frames
        bus2.payload = 1'b1;
        bus2.start = 1'b1;
        step();
        chk("t6_accept", obs2(), 5'b00000);
        for (int f = 0; f < 2; f++) begin
            bus2.start = (f == 0);
            for (int i = 0; i < 7; i++) begin
                step();
                chk($sformatf("t6_f%0d_sym%0d", f, i), obs2(), {2'b10, SEQ_P1[(6-i)*3 +: 3]});
            end
            step();
            chk($sformatf("t6_f%0d_done", f), obs2(), 5'b01000);
        end
        step();
        chk("t6_after", obs2(), 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
